data_memory_responder: RTL

Word-addressed data memory that answers the Mips pipeline's MEM-stage load/store requests with a configurable number of wait states. It is the responder end of the MEM-stage memory interface. It drives the load data that the pipeline registers into Read_Data_WB. It also drives a stall that the hazard logic ORs into pc_stall and IF_ID_pipeline_stall so the whole pipeline freezes while an access is outstanding.

---
 rtl/data_memory_responder_if.sv | 31 +++
 rtl/data_memory_responder.sv | 112 +++++++++++
 2 files changed

// File: rtl/data_memory_responder_if.sv
// MEM-stage memory bus between the pipeline (master) and the data memory
// responder (slave). Signal names match the pipeline's MEM-stage wiring.
// Handshake: a request is MemRead_MEM | MemWrite_MEM, held level by the
// master while Mem_Stall is high; the access commits on the edge ending the
// first cycle in which the request is present and Mem_Stall is low, and
// Mem_Ready pulses for exactly the following cycle.
interface data_memory_responder_if;
    logic        MemRead_MEM;
    logic        MemWrite_MEM;
    logic [31:0] Address_MEM;
    logic [31:0] Write_Data_MEM;
    logic [31:0] Read_Data_MEM;
    logic        Mem_Stall;
    logic        Mem_Ready;
    logic        Access_Error;
    // Debug view of the responder FSM (state and wait counter)
    logic        fsm_state;
    logic [3:0]  wait_cnt;

    modport master (
        output MemRead_MEM, MemWrite_MEM, Address_MEM, Write_Data_MEM,
        input  Read_Data_MEM, Mem_Stall, Mem_Ready, Access_Error,
        input  fsm_state, wait_cnt
    );

    modport slave (
        input  MemRead_MEM, MemWrite_MEM, Address_MEM, Write_Data_MEM,
        output Read_Data_MEM, Mem_Stall, Mem_Ready, Access_Error,
        output fsm_state, wait_cnt
    );
endinterface

// File: rtl/data_memory_responder.sv
// Word-addressed data memory answering MEM-stage loads/stores after a fixed
// number of wait states. Address/data are sampled at the commit edge, not at
// accept, because the pipeline holds them stable while stalled.
module data_memory_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    data_memory_responder_if.slave mem
);
    localparam logic [0:0] IDLE       = 1'b0;
    localparam logic [0:0] WAIT       = 1'b1;
    localparam logic [3:0] WAIT_LIMIT = 4'(WAIT_CYCLES);
    localparam logic       NO_WAIT    = (WAIT_CYCLES == 0);
    localparam int         DEPTH      = 1 << ADDR_WIDTH;

    logic [0:0]            state;
    logic [3:0]            cnt;
    logic [31:0]           array [DEPTH];
    logic [31:0]           read_data;
    logic                  ready;
    logic                  error;

    logic                  request;
    logic                  misaligned;
    logic                  both;
    logic [ADDR_WIDTH-1:0] index;
    logic                  commit;
    logic                  do_access;
    logic                  write_en;
    logic                  load_en;
    logic                  zero_load;
    logic                  err_set;
    logic                  unused_addr_bits;

    assign request    = mem.MemRead_MEM | mem.MemWrite_MEM;
    assign both       = mem.MemRead_MEM & mem.MemWrite_MEM;
    assign misaligned = (mem.Address_MEM[1:0] != 2'b00);
    // Upper address bits are dropped so the address space wraps
    assign index            = mem.Address_MEM[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^mem.Address_MEM[31:ADDR_WIDTH+2];

    // Commit edge: immediately with no wait states, else when the count ends.
    // Gated by reset so an access in flight is aborted without side effects.
    assign commit = Reset_n &
                    (((state == IDLE) & request & NO_WAIT) |
                     ((state == WAIT) & (cnt == WAIT_LIMIT)));

    // A request dropped during WAIT still finishes the count but touches nothing
    assign do_access = commit & request;
    assign write_en  = do_access & mem.MemWrite_MEM & ~misaligned;
    assign load_en   = do_access & mem.MemRead_MEM & ~mem.MemWrite_MEM & ~misaligned;
    assign zero_load = do_access & mem.MemRead_MEM & ~mem.MemWrite_MEM & misaligned;
    assign err_set   = do_access & (misaligned | both);

    assign mem.Mem_Stall = Reset_n &
                           (((state == IDLE) & request & ~NO_WAIT) |
                            ((state == WAIT) & (cnt < WAIT_LIMIT)));

    assign mem.Read_Data_MEM = read_data;
    assign mem.Mem_Ready     = ready;
    assign mem.Access_Error  = error;
    assign mem.fsm_state     = state;
    assign mem.wait_cnt      = cnt;

    // Wait-state FSM: accept in IDLE, count up to WAIT_CYCLES, then return
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else if (state == IDLE) begin
            if (request && !NO_WAIT) begin
                state <= WAIT;
                cnt   <= 4'd1;
            end
        end else begin
            if (cnt == WAIT_LIMIT) begin
                state <= IDLE;
                cnt   <= 4'd0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    // Load data, ready pulse and sticky error flag update at the commit edge
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            read_data <= 32'h0;
            ready     <= 1'b0;
            error     <= 1'b0;
        end else begin
            ready <= commit;
            if (err_set) begin
                error <= 1'b1;
            end
            if (load_en) begin
                read_data <= array[index];
            end else if (zero_load) begin
                read_data <= 32'h0;
            end
        end
    end

    // Storage array: not reset, contents survive Reset_n
    always_ff @(posedge Clk) begin
        if (write_en) begin
            array[index] <= mem.Write_Data_MEM;
        end
    end
endmodule
